// File: rtl/stac_pkg.sv
// Shared definitions for the STAC TAP driver: controller states, IR opcodes
// selecting the test data registers, and the lengths of those registers.
package stac_pkg;

    typedef enum logic [3:0] {
        RST_SEQ,
        IDLE,
        SEL_DR,
        SEL_IR,
        CAPTURE,
        SHIFT,
        EXIT1,
        UPDATE,
        RESP
    } stac_state_e;

    localparam int         IR_LEN      = 8;
    localparam logic [7:0] IR_SEL_TDR1 = 8'h11;
    localparam logic [7:0] IR_SEL_TDR2 = 8'h12;
    localparam int         TDR1_LEN    = 17;
    localparam int         TDR2_LEN    = 33;

    // Width of the scan length field and of the bit counter.
    localparam int         LEN_W       = 6;

endpackage

// File: rtl/stac_shift_unit.sv
// Serial datapath of the TAP driver: holds the command bits, selects the WSI
// bit for the coming cycle, captures WSO and keeps the bit counter.
module stac_shift_unit
    import stac_pkg::*;
#(
    parameter int MAX_LEN = TDR2_LEN
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [LEN_W-1:0]   load_len,
    input  logic [MAX_LEN-1:0] load_data,
    input  logic               shift_en,
    input  logic               wso,
    output logic               wsi_next,
    output logic               last,
    output logic               last_next,
    output logic [MAX_LEN-1:0] capture
);
    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);

    logic [LEN_W-1:0]   count;
    logic [LEN_W-1:0]   count_next;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q;

    // The counter only advances on shift cycles, so during shift cycle j it reads j.
    always_comb begin
        count_next = count;
        if (load) begin
            count_next = '0;
        end else if (shift_en) begin
            count_next = count + 1'b1;
        end
    end

    always_comb begin
        wsi_next  = 1'b0;
        if (count_next < MAX_LEN_W) begin
            wsi_next = data_q[count_next];
        end
        last      = (count == len_q - 1'b1);
        last_next = (count_next == len_q - 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            capture <= '0;
        end else begin
            count <= count_next;
            if (load) begin
                len_q   <= load_len;
                data_q  <= load_data;
                capture <= '0;
            end else if (shift_en) begin
                capture[count] <= wso;
            end
        end
    end

endmodule

// File: rtl/stac_tap_driver.sv
// STAC TAP driver: mirrors the STAC controller state and turns scan commands
// into registered TMS/WSI sequences, returning the captured WSO bits.
module stac_tap_driver
    import stac_pkg::*;
#(
    parameter int MAX_LEN    = TDR2_LEN,
    parameter int RST_CYCLES = 5
) (
    input  logic               TCLK,
    input  logic               TRESETN,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_is_ir,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               rsp_valid,
    output logic               rsp_err,
    output logic [MAX_LEN-1:0] rsp_data,
    output logic               TMS,
    output logic               WSI,
    input  logic               WSO
);
    localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
    localparam logic [7:0]       RST_LAST  = 8'(RST_CYCLES);

    stac_state_e        state;
    stac_state_e        state_next;
    logic [7:0]         rst_cnt;
    logic [7:0]         rst_cnt_next;
    logic               is_ir_q;
    logic               accept;
    logic               len_ok;
    logic               shift_en;
    logic               tms_next;
    logic               wsi_d;
    logic               wsi_next;
    logic               last;
    logic               last_next;
    logic [MAX_LEN-1:0] capture;

    assign len_ok = (cmd_len != '0) && (cmd_len <= MAX_LEN_W);

    stac_shift_unit #(
        .MAX_LEN (MAX_LEN)
    ) u_shift (
        .clk       (TCLK),
        .rst_n     (TRESETN),
        .load      (accept),
        .load_len  (cmd_len),
        .load_data (cmd_data),
        .shift_en  (shift_en),
        .wso       (WSO),
        .wsi_next  (wsi_next),
        .last      (last),
        .last_next (last_next),
        .capture   (capture)
    );

    // TMS/WSI are registered from the next state, so each lines up with the state it drives.
    always_ff @(posedge TCLK or negedge TRESETN) begin
        if (!TRESETN) begin
            state    <= RST_SEQ;
            rst_cnt  <= '0;
            is_ir_q  <= 1'b0;
            TMS      <= 1'b1;
            WSI      <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            state   <= state_next;
            rst_cnt <= rst_cnt_next;
            TMS     <= tms_next;
            WSI     <= wsi_d;
            if (accept) begin
                is_ir_q <= cmd_is_ir;
            end
            // RESP is reached straight from IDLE only for a rejected command.
            if (state_next == RESP) begin
                rsp_err  <= (state == IDLE);
                rsp_data <= (state == IDLE) ? '0 : capture;
            end
        end
    end

    always_comb begin
        state_next   = state;
        rst_cnt_next = '0;
        unique case (state)
            RST_SEQ: begin
                if (rst_cnt == RST_LAST) begin
                    state_next = IDLE;
                end else begin
                    rst_cnt_next = rst_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    state_next = len_ok ? SEL_DR : RESP;
                end
            end
            SEL_DR:  state_next = is_ir_q ? SEL_IR : CAPTURE;
            SEL_IR:  state_next = CAPTURE;
            CAPTURE: state_next = SHIFT;
            SHIFT: begin
                if (last) begin
                    state_next = EXIT1;
                end
            end
            EXIT1:   state_next = UPDATE;
            UPDATE:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = RST_SEQ;
        endcase
    end

    always_comb begin
        cmd_ready = (state == IDLE);
        rsp_valid = (state == RESP);
        shift_en  = (state == SHIFT);
        accept    = cmd_valid && cmd_ready;
        tms_next  = 1'b0;
        wsi_d     = 1'b0;
        case (state_next)
            RST_SEQ:                      tms_next = (rst_cnt_next != RST_LAST);
            SEL_DR, SEL_IR, EXIT1, UPDATE: tms_next = 1'b1;
            SHIFT: begin
                tms_next = last_next;
                wsi_d    = wsi_next;
            end
            default:                      tms_next = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_stac_tap_driver.sv
// Randomized scoreboard bench for stac_tap_driver: per-cycle TMS/WSI/ready
// expectations and a response queue, each checked by its own monitor.
`timescale 1ns/1ps
module tb_stac_tap_driver;
    import stac_pkg::*;

    localparam int MAX_LEN    = TDR2_LEN;
    localparam int RST_CYCLES = 5;

    typedef struct {
        int                 due;
        logic               err;
        logic [MAX_LEN-1:0] data;
    } resp_t;

    logic               TCLK      = 1'b0;
    logic               TRESETN   = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic               cmd_is_ir = 1'b0;
    logic [5:0]         cmd_len   = '0;
    logic [MAX_LEN-1:0] cmd_data  = '0;
    logic               rsp_valid;
    logic               rsp_err;
    logic [MAX_LEN-1:0] rsp_data;
    logic               TMS;
    logic               WSI;
    logic               WSO       = 1'b0;

    int                 cyc       = 0;
    int                 check_cnt = 0;
    int                 err_cnt   = 0;

    logic               exp_tms[int];
    logic               exp_wsi[int];
    logic               exp_ready[int];
    logic               wso_at[int];
    resp_t              exp_q[$];
    resp_t              mon_e;

    logic [MAX_LEN-1:0] hold_data       = '0;
    logic               hold_err        = 1'b0;
    bit                 hold_data_known = 1'b1;

    stac_tap_driver #(
        .MAX_LEN    (MAX_LEN),
        .RST_CYCLES (RST_CYCLES)
    ) dut (
        .TCLK      (TCLK),
        .TRESETN   (TRESETN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_is_ir (cmd_is_ir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .TMS       (TMS),
        .WSI       (WSI),
        .WSO       (WSO)
    );

    always #5 TCLK = ~TCLK;

    always @(posedge TCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        check_cnt++;
        if (actual !== expected) begin
            err_cnt++;
            $display("[TB] FAIL %s cycle %0d actual %0h expected %0h", name, cyc, actual, expected);
        end
    endtask

    // The emulated STAC returns scheduled bits during shift cycles and noise elsewhere.
    always @(negedge TCLK) begin
        if (wso_at.exists(cyc)) WSO = wso_at[cyc];
        else                    WSO = 1'($urandom_range(0, 1));
    end

    always @(negedge TCLK) begin
        if (TRESETN) begin
            if (exp_tms.exists(cyc))   checkOutput("tms", 64'(TMS), 64'(exp_tms[cyc]));
            if (exp_wsi.exists(cyc))   checkOutput("wsi", 64'(WSI), 64'(exp_wsi[cyc]));
            if (exp_ready.exists(cyc)) checkOutput("cmd_ready", 64'(cmd_ready), 64'(exp_ready[cyc]));
            if (rsp_valid) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    err_cnt++;
                    $display("[TB] FAIL unexpected_rsp cycle %0d actual rsp_valid 1 expected 0", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rsp_cycle", 64'(cyc), 64'(mon_e.due));
                    checkOutput("rsp_err", 64'(rsp_err), 64'(mon_e.err));
                    if (!mon_e.err) checkOutput("rsp_data", 64'(rsp_data), 64'(mon_e.data));
                    hold_err        = mon_e.err;
                    hold_data       = mon_e.data;
                    hold_data_known = !mon_e.err;
                end
            end else begin
                checkOutput("hold_err", 64'(rsp_err), 64'(hold_err));
                if (hold_data_known) checkOutput("hold_data", 64'(rsp_data), 64'(hold_data));
            end
        end
    end

    // Expected stream from acceptance cycle c, built from the command-sequence rules.
    task automatic scheduleCommand(input int c, input logic is_ir, input logic [5:0] len,
                                   input logic [MAX_LEN-1:0] data, input logic [MAX_LEN-1:0] wso_bits,
                                   output int due);
        int    lead = is_ir ? 4 : 3;
        int    lat;
        resp_t r;
        r.data = '0;
        if (len == 0 || len > MAX_LEN) begin
            lat   = 1;
            r.err = 1'b1;
            exp_tms[c + 1] = 1'b0;
            exp_wsi[c + 1] = 1'b0;
        end else begin
            lat   = int'(len) + lead + 2;
            r.err = 1'b0;
            for (int k = 1; k <= lat; k++) exp_wsi[c + k] = 1'b0;
            exp_tms[c + 1] = 1'b1;
            if (is_ir) exp_tms[c + 2] = 1'b1;
            exp_tms[c + lead - 1] = 1'b0;
            for (int j = 0; j < int'(len); j++) begin
                exp_tms[c + lead + j] = (j == int'(len) - 1);
                exp_wsi[c + lead + j] = data[j];
                wso_at[c + lead + j]  = wso_bits[j];
                r.data[j]             = wso_bits[j];
            end
            exp_tms[c + lead + int'(len)]     = 1'b1;
            exp_tms[c + lead + int'(len) + 1] = 1'b1;
            exp_tms[c + lead + int'(len) + 2] = 1'b0;
        end
        for (int k = 1; k <= lat; k++) exp_ready[c + k] = 1'b0;
        exp_ready[c + lat + 1] = 1'b1;
        exp_tms[c + lat + 1]   = 1'b0;
        exp_wsi[c + lat + 1]   = 1'b0;
        r.due = c + lat;
        due   = r.due;
        exp_q.push_back(r);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic applyStimulus(input logic is_ir, input logic [5:0] len, input logic [MAX_LEN-1:0] data,
                                 input logic [MAX_LEN-1:0] wso_bits, input bit hold_valid,
                                 output int acc, output int due);
        int wait_cnt = 0;
        cmd_is_ir = is_ir;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid = 1'b1;
        while (cmd_ready !== 1'b1 && wait_cnt < 200) begin
            @(negedge TCLK);
            wait_cnt++;
        end
        if (cmd_ready !== 1'b1) begin
            check_cnt++;
            err_cnt++;
            $display("[TB] FAIL accept_timeout cycle %0d actual cmd_ready %b expected 1", cyc, cmd_ready);
            cmd_valid = 1'b0;
            acc = -1;
            due = -1;
            return;
        end
        acc = cyc;
        scheduleCommand(acc, is_ir, len, data, wso_bits, due);
        @(negedge TCLK);
        cmd_valid = hold_valid;
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge TCLK);
            n++;
        end
        if (exp_q.size() != 0) begin
            check_cnt++;
            err_cnt++;
            $display("[TB] FAIL rsp_timeout cycle %0d actual pending %0d expected 0", cyc, exp_q.size());
            exp_q.delete();
        end
        @(negedge TCLK);
    endtask

    task automatic doReset(input int low_cycles);
        int r;
        @(negedge TCLK);
        exp_tms.delete();
        exp_wsi.delete();
        exp_ready.delete();
        wso_at.delete();
        exp_q.delete();
        cmd_valid = 1'b0;
        #2 TRESETN = 1'b0;
        for (int i = 0; i < low_cycles; i++) begin
            @(negedge TCLK);
            checkOutput("rst_tms", 64'(TMS), 64'd1);
            checkOutput("rst_wsi", 64'(WSI), 64'd0);
            checkOutput("rst_ready", 64'(cmd_ready), 64'd0);
            checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
            checkOutput("rst_rsp_err", 64'(rsp_err), 64'd0);
            checkOutput("rst_rsp_data", 64'(rsp_data), 64'd0);
        end
        r = cyc;
        #2 TRESETN = 1'b1;
        hold_data       = '0;
        hold_err        = 1'b0;
        hold_data_known = 1'b1;
        for (int k = 1; k <= RST_CYCLES; k++) begin
            exp_tms[r + k]   = (k < RST_CYCLES);
            exp_ready[r + k] = 1'b0;
            exp_wsi[r + k]   = 1'b0;
        end
        exp_tms[r + RST_CYCLES + 1]   = 1'b0;
        exp_ready[r + RST_CYCLES + 1] = 1'b1;
    endtask

    function automatic logic [MAX_LEN-1:0] randBits();
        return MAX_LEN'({$urandom(), $urandom()});
    endfunction

    initial begin
        int acc;
        int due;
        int prev_due;
        logic [5:0] len;

        doReset(3);
        @(negedge TCLK);

        applyStimulus(1'b1, 6'd8, MAX_LEN'(IR_SEL_TDR1) ^ MAX_LEN'(8'hB4), randBits(), 1'b0, acc, due);
        waitDrain();
        applyStimulus(1'b0, 6'(TDR1_LEN), MAX_LEN'(17'h1_2345), MAX_LEN'(17'h0_ABCD), 1'b0, acc, due);
        waitDrain();
        applyStimulus(1'b0, 6'd0, randBits(), randBits(), 1'b0, acc, due);
        waitDrain();
        applyStimulus(1'b1, 6'd34, randBits(), randBits(), 1'b0, acc, due);
        waitDrain();
        applyStimulus(1'b0, 6'd1, randBits(), randBits(), 1'b0, acc, due);
        waitDrain();
        applyStimulus(1'b1, 6'd1, randBits(), randBits(), 1'b0, acc, due);
        waitDrain();

        // Abort a full-length scan at shift bit 10, then expect a clean replay.
        applyStimulus(1'b0, 6'(TDR2_LEN), randBits(), randBits(), 1'b0, acc, due);
        while (acc >= 0 && cyc < acc + 12) @(negedge TCLK);
        doReset(2);
        @(negedge TCLK);
        applyStimulus(1'b0, 6'(TDR2_LEN), randBits(), randBits(), 1'b0, acc, due);
        waitDrain();

        // Back-to-back with cmd_valid held: each acceptance lands on the first IDLE cycle.
        applyStimulus(1'b1, 6'd5, randBits(), randBits(), 1'b1, acc, prev_due);
        for (int i = 0; i < 5; i++) begin
            len = (i == 2) ? 6'd0 : 6'($urandom_range(1, MAX_LEN));
            applyStimulus(1'($urandom_range(0, 1)), len, randBits(), randBits(), i < 4, acc, due);
            checkOutput("b2b_accept", 64'(acc), 64'(prev_due + 1));
            prev_due = due;
        end
        waitDrain();

        for (int i = 0; i < 30; i++) begin
            len = 6'($urandom_range(0, 36));
            applyStimulus(1'($urandom_range(0, 1)), len, randBits(), randBits(), 1'b0, acc, due);
            repeat ($urandom_range(0, 3)) @(negedge TCLK);
        end
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cycle %0d actual running expected finished", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
